// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display path. The pattern
// constants are the same ones the binary-to-segment encoder drives, so the
// capture side decodes exactly what the encoder produces.
//   SEG_0..SEG_9 : segment patterns, bit0 = a ... bit6 = g, active-high
//   SEG_BLANK    : all segments off
//   BAD_DIGIT    : nibble reported for any pattern that is not a digit
//   seg_state_t  : capture FSM states
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BAD_DIGIT = 4'hF;

    // SETTLE waits for a stable one-hot sample; HOLD blocks re-accepting it
    typedef enum logic {
        SETTLE,
        HOLD
    } seg_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg_pattern_decode
// Combinational inverse of the segment encoder: maps a 7-bit segment pattern
// back to its decimal value. Anything that is not one of the ten digit
// patterns (blank included) comes out as BAD_DIGIT with o_invalid set.
//   i_pattern : segment pattern, bit0 = a ... bit6 = g
//   o_value   : decoded digit 0-9, or BAD_DIGIT
//   o_invalid : high when the pattern is not a digit
// ---------------------------------------------------------------------------
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_value,
    output logic       o_invalid
);

    // Full table lookup; the default arm covers every non-digit pattern
    always_comb begin
        o_value   = BAD_DIGIT;
        o_invalid = 1'b1;
        case (i_pattern)
            SEG_0:     begin o_value = 4'd0; o_invalid = 1'b0; end
            SEG_1:     begin o_value = 4'd1; o_invalid = 1'b0; end
            SEG_2:     begin o_value = 4'd2; o_invalid = 1'b0; end
            SEG_3:     begin o_value = 4'd3; o_invalid = 1'b0; end
            SEG_4:     begin o_value = 4'd4; o_invalid = 1'b0; end
            SEG_5:     begin o_value = 4'd5; o_invalid = 1'b0; end
            SEG_6:     begin o_value = 4'd6; o_invalid = 1'b0; end
            SEG_7:     begin o_value = 4'd7; o_invalid = 1'b0; end
            SEG_8:     begin o_value = 4'd8; o_invalid = 1'b0; end
            SEG_9:     begin o_value = 4'd9; o_invalid = 1'b0; end
            SEG_BLANK: begin o_value = BAD_DIGIT; o_invalid = 1'b1; end
            default:   begin o_value = BAD_DIGIT; o_invalid = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// ---------------------------------------------------------------------------
// seg_capture
// Watches a multiplexed seven-segment bus and rebuilds the displayed
// multi-digit decimal value. A {digit_en, seg} sample must stay unchanged
// for STABLE_CYCLES sampled cycles before it is accepted into its slot;
// once every position has been accepted the whole frame is published.
//   i_clk          : clock, rising edge
//   i_rst          : synchronous active-high reset
//   i_seg_in       : segment pattern, bit0 = a ... bit6 = g
//   i_digit_en     : one-hot digit position enable
//   o_digits_out   : published frame, nibble i = position i (BAD_DIGIT if bad)
//   o_frame_valid  : one-cycle pulse when o_digits_out updates
//   o_frame_err    : high when the published frame holds any BAD_DIGIT
// ---------------------------------------------------------------------------
module seg_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [6:0]              i_seg_in,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    output logic [4*NUM_DIGITS-1:0] o_digits_out,
    output logic                    o_frame_valid,
    output logic                    o_frame_err
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0]           r_sample;
    logic [CW-1:0]           r_count;
    seg_state_t              r_state;
    seg_state_t              w_next_state;
    logic [SW-1:0]           w_sample_in;
    logic                    w_changed;
    logic [NUM_DIGITS-1:0]   w_en;
    logic [6:0]              w_seg;
    logic                    w_onehot;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_accept_mask;
    logic [3:0]              w_value;
    logic                    w_invalid;
    logic                    w_complete;
    logic [4*NUM_DIGITS-1:0] r_buffer;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_err_acc;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic                    r_valid;
    logic                    r_err;

    assign w_sample_in   = {i_digit_en, i_seg_in};
    assign w_changed     = (w_sample_in != r_sample);
    assign w_en          = r_sample[SW-1:7];
    assign w_seg         = r_sample[6:0];
    assign w_onehot      = (w_en != '0) &&
                           ((w_en & (w_en - NUM_DIGITS'(1))) == '0);
    assign w_accept_mask = w_accept ? w_en : '0;
    assign w_complete    = &r_seen;

    seg_pattern_decode u_decode (
        .i_pattern (w_seg),
        .o_value   (w_value),
        .o_invalid (w_invalid)
    );

    // Input register and stability counter. The counter saturates at the
    // accept threshold so a long hold cannot wrap round into a false accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample <= '0;
            r_count  <= '0;
        end else begin
            r_sample <= w_sample_in;
            if (w_changed) begin
                r_count <= '0;
            end else if (r_count != CNT_MAX) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SETTLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. If the sample changes on the very edge that accepts
    // it, we stay in SETTLE so the new sample can still be accepted later;
    // going to HOLD there would miss that change and lock the new pattern out.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            SETTLE: begin
                if ((r_count == CNT_MAX) && w_onehot) begin
                    w_accept     = 1'b1;
                    w_next_state = w_changed ? SETTLE : HOLD;
                end
            end
            HOLD: begin
                if (w_changed) begin
                    w_next_state = SETTLE;
                end
            end
            default: w_next_state = SETTLE;
        endcase
    end

    // Frame assembly and publish. When seen is full the old buffer is
    // published and a fresh frame starts from whatever is accepted on the
    // same edge, so that digit is carried into the next frame, not dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buffer  <= '0;
            r_seen    <= '0;
            r_err_acc <= 1'b0;
            r_digits  <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_accept_mask[i]) begin
                    r_buffer[4*i +: 4] <= w_value;
                end
            end
            r_valid <= w_complete;
            if (w_complete) begin
                r_digits  <= r_buffer;
                r_err     <= r_err_acc;
                r_seen    <= w_accept_mask;
                r_err_acc <= w_accept & w_invalid;
            end else begin
                r_seen    <= r_seen | w_accept_mask;
                r_err_acc <= r_err_acc | (w_accept & w_invalid);
            end
        end
    end

    assign o_digits_out  = r_digits;
    assign o_frame_valid = r_valid;
    assign o_frame_err   = r_err;

endmodule

// File: tb/tb_seg_capture.sv
// ---------------------------------------------------------------------------
// tb_seg_capture
// Directed bench for seg_capture (NUM_DIGITS = 4, STABLE_CYCLES = 4).
// Inputs change on the falling edge and outputs are read on the falling
// edge, half a cycle away from the rising edge the design uses.
// ---------------------------------------------------------------------------
module tb_seg_capture;

    logic        clock;
    logic        reset;
    logic [6:0]  segIn;
    logic [3:0]  digitEn;
    logic [15:0] digitsOut;
    logic        frameValid;
    logic        frameErr;

    int          checkCount = 0;
    int          errorCount = 0;
    int          pulseCount = 0;
    int          base;
    logic        prevValid  = 1'b0;
    logic [6:0]  segTab [10];

    seg_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .i_clk         (clock),
        .i_rst         (reset),
        .i_seg_in      (segIn),
        .i_digit_en    (digitEn),
        .o_digits_out  (digitsOut),
        .o_frame_valid (frameValid),
        .o_frame_err   (frameErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one bus value and hold it for the given number of cycles
    task automatic applyStimulus(input logic [3:0] en, input logic [6:0] seg,
                                 input int cycles);
        digitEn = en;
        segIn   = seg;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic sendDigit(input int pos, input int val, input int cycles);
        applyStimulus(4'(1 << pos), segTab[val], cycles);
    endtask

    task automatic idle(input int cycles);
        applyStimulus(4'b0000, 7'b0000000, cycles);
    endtask

    // Counts publish pulses and makes sure two never arrive back to back
    always @(negedge clock) begin
        if (frameValid) begin
            pulseCount++;
            checkOutput("valid_gap", 32'(prevValid), 32'd0);
        end
        prevValid = frameValid;
    end

    initial begin
        segTab[0] = 7'b0111111;
        segTab[1] = 7'b0000110;
        segTab[2] = 7'b1011011;
        segTab[3] = 7'b1001111;
        segTab[4] = 7'b1100110;
        segTab[5] = 7'b1101101;
        segTab[6] = 7'b1111101;
        segTab[7] = 7'b0000111;
        segTab[8] = 7'b1111111;
        segTab[9] = 7'b1101111;

        reset   = 1'b1;
        segIn   = 7'b0;
        digitEn = 4'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_digits", 32'(digitsOut), 32'h0);
        checkOutput("rst_valid", 32'(frameValid), 32'd0);
        checkOutput("rst_err", 32'(frameErr), 32'd0);
        reset = 1'b0;

        $display("[TB] basic frame 1,2,3,4");
        base = pulseCount;
        sendDigit(0, 1, 5);
        sendDigit(1, 2, 5);
        sendDigit(2, 3, 5);
        sendDigit(3, 4, 5);
        checkOutput("lat_before", 32'(frameValid), 32'd0);
        idle(1);
        checkOutput("lat_valid", 32'(frameValid), 32'd1);
        checkOutput("f1_digits", 32'(digitsOut), 32'h4321);
        checkOutput("f1_err", 32'(frameErr), 32'd0);
        idle(1);
        checkOutput("pulse_width", 32'(frameValid), 32'd0);
        idle(3);
        checkOutput("f1_pulses", 32'(pulseCount - base), 32'd1);

        $display("[TB] long hold on position 2");
        base = pulseCount;
        sendDigit(0, 5, 5);
        sendDigit(1, 6, 5);
        sendDigit(2, 7, 100);
        idle(3);
        checkOutput("hold_nopulse", 32'(pulseCount - base), 32'd0);
        sendDigit(3, 8, 5);
        idle(3);
        checkOutput("hold_pulses", 32'(pulseCount - base), 32'd1);
        checkOutput("hold_digits", 32'(digitsOut), 32'h8765);
        idle(20);
        checkOutput("hold_noextra", 32'(pulseCount - base), 32'd1);

        $display("[TB] glitch rejection");
        base = pulseCount;
        sendDigit(0, 9, 5);
        sendDigit(1, 8, 2);
        sendDigit(1, 6, 3);
        sendDigit(1, 5, 5);
        sendDigit(2, 0, 5);
        sendDigit(3, 3, 5);
        idle(3);
        checkOutput("glitch_pulses", 32'(pulseCount - base), 32'd1);
        checkOutput("glitch_slot1", 32'(digitsOut[7:4]), 32'h5);
        checkOutput("glitch_digits", 32'(digitsOut), 32'h3059);
        checkOutput("glitch_err", 32'(frameErr), 32'd0);

        $display("[TB] invalid pattern then clean frame");
        base = pulseCount;
        sendDigit(0, 1, 5);
        sendDigit(1, 1, 5);
        sendDigit(2, 1, 5);
        applyStimulus(4'b1000, 7'b1110000, 5);
        idle(3);
        checkOutput("bad_pulses", 32'(pulseCount - base), 32'd1);
        checkOutput("bad_digits", 32'(digitsOut), 32'hF111);
        checkOutput("bad_err", 32'(frameErr), 32'd1);
        // minimum-length holds, each change landing on the accepting edge
        sendDigit(0, 2, 4);
        sendDigit(1, 2, 4);
        sendDigit(2, 2, 4);
        sendDigit(3, 2, 4);
        idle(3);
        checkOutput("clean_pulses", 32'(pulseCount - base), 32'd2);
        checkOutput("clean_digits", 32'(digitsOut), 32'h2222);
        checkOutput("clean_err", 32'(frameErr), 32'd0);

        $display("[TB] multi-hot and zero enables");
        base = pulseCount;
        applyStimulus(4'b0110, segTab[8], 20);
        applyStimulus(4'b0000, segTab[8], 20);
        checkOutput("mh_nopulse", 32'(pulseCount - base), 32'd0);
        sendDigit(0, 3, 5);
        sendDigit(3, 6, 5);
        idle(3);
        checkOutput("mh_seen", 32'(pulseCount - base), 32'd0);
        sendDigit(1, 7, 5);
        sendDigit(2, 9, 5);
        idle(3);
        checkOutput("mh_pulses", 32'(pulseCount - base), 32'd1);
        checkOutput("mh_digits", 32'(digitsOut), 32'h6973);
        checkOutput("mh_err", 32'(frameErr), 32'd0);

        $display("[TB] reset mid-frame");
        sendDigit(0, 8, 5);
        applyStimulus(4'b0010, 7'b0000000, 5);
        sendDigit(2, 8, 5);
        reset = 1'b1;
        idle(2);
        checkOutput("mid_rst_digits", 32'(digitsOut), 32'h0);
        checkOutput("mid_rst_err", 32'(frameErr), 32'd0);
        reset = 1'b0;
        base  = pulseCount;
        sendDigit(3, 9, 5);
        idle(3);
        checkOutput("mid_rst_seen", 32'(pulseCount - base), 32'd0);
        sendDigit(0, 1, 5);
        sendDigit(1, 2, 5);
        sendDigit(2, 3, 5);
        idle(3);
        checkOutput("mid_rst_pulses", 32'(pulseCount - base), 32'd1);
        checkOutput("mid_rst_frame", 32'(digitsOut), 32'h9321);
        checkOutput("mid_rst_ferr", 32'(frameErr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
